// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchroniser plus 4-state filter FSM. key_level follows a stable key_in after N+3 edges. No backpressure.
// Optional KEY_DEBOUNCE_LONGPRESS_EN adds a one-shot long_press pulse after LONG_CYCLES in the pressed state.
module key_debounce #(
    parameter int   CNT_W           = 20,
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter logic IDLE_LEVEL      = 1'b1,
    parameter int   LONG_CYCLES     = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic busy,
    output logic long_press
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILT_PRESS = 2'd1,
        ACTIVE     = 2'd2,
        FILT_REL   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             ACTIVE_LEVEL = ~IDLE_LEVEL;

    if (DEBOUNCE_CYCLES < 1 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
    end
    if (LONG_CYCLES < 1 || LONG_CYCLES >= (1 << 26)) begin : g_bad_long
        $error("key_debounce: LONG_CYCLES must be in 1 .. 2^26-1");
    end

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= IDLE_LEVEL;
            s2 <= IDLE_LEVEL;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    // Any disagreement inside a filter window drops back and restarts from zero later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_level <= IDLE_LEVEL;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s2 != IDLE_LEVEL) begin
                        state <= FILT_PRESS;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FILT_PRESS: begin
                    if (s2 == IDLE_LEVEL) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ACTIVE;
                        cnt       <= '0;
                        key_level <= ACTIVE_LEVEL;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (s2 == IDLE_LEVEL) begin
                        state <= FILT_REL;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FILT_REL: begin
                    if (s2 != IDLE_LEVEL) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        key_level <= IDLE_LEVEL;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    key_level <= IDLE_LEVEL;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam logic [25:0] LP_FIRE = 26'(LONG_CYCLES - 1);
    localparam logic [25:0] LP_SAT  = 26'(LONG_CYCLES);

    logic [25:0] lp_cnt;
    logic        press_done;

    assign press_done = (state == FILT_PRESS) && (s2 != IDLE_LEVEL) && (cnt == CNT_LAST);

    // Saturating one past the fire point guarantees a single pulse per press;
    // an aborted release keeps the count, so the hold time carries over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt     <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (press_done) begin
                lp_cnt <= '0;
            end else if (state == ACTIVE && lp_cnt != LP_SAT) begin
                lp_cnt     <= lp_cnt + 26'd1;
                long_press <= (lp_cnt == LP_FIRE);
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed tables, hand sequences and random stimulus against a run-length model.
module tb_key_debounce;

    localparam int   N    = 8;
    localparam logic IDLE = 1'b1;
    localparam int   L    = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic key_in;
    logic key_level;
    logic busy;
    logic long_press;

    always #5 clk = ~clk;

    key_debounce #(
        .CNT_W          (4),
        .DEBOUNCE_CYCLES(N),
        .IDLE_LEVEL     (IDLE),
        .LONG_CYCLES    (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_level (key_level),
        .busy      (busy),
        .long_press(long_press)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: the synchroniser is a two-sample delay line; the level flips once
    // N+1 consecutive delayed samples disagree with it.
    logic hist[$];
    logic m_lvl;
    int   m_run;
    int   m_act;
    logic m_busy;
    logic m_lp;

    typedef struct {
        logic k;
        int   n;
        logic exp_lvl;
        logic exp_busy;
    } seg_t;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(IDLE);
        hist.push_back(IDLE);
        m_lvl  = IDLE;
        m_run  = 0;
        m_act  = 0;
        m_busy = 1'b0;
        m_lp   = 1'b0;
    endtask

    task automatic model_edge();
        logic seen;
        bit   pressed_steady;
        seen = hist.pop_front();
        hist.push_back(key_in);
        pressed_steady = (m_lvl != IDLE) && (m_run == 0);
        m_lp = 1'b0;
        if (pressed_steady) begin
            m_act++;
            if (m_act == L) m_lp = 1'b1;
        end
        if (seen != m_lvl) m_run++;
        else m_run = 0;
        if (m_run == N + 1) begin
            m_lvl = ~m_lvl;
            m_run = 0;
            m_act = 0;
        end
        m_busy = (m_run != 0);
`ifndef KEY_DEBOUNCE_LONGPRESS_EN
        m_lp = 1'b0;
`endif
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cyc(input logic k);
        key_in = k;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_level", key_level, m_lvl);
        chk("model_busy", busy, m_busy);
        chk("model_long_press", long_press, m_lp);
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_level", key_level, IDLE);
        chk("rst_busy", busy, 1'b0);
        chk("rst_long_press", long_press, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Hold k for 11 edges; level must still be old after 10 and new after 11.
    task automatic accept_11(input logic k, input string nm);
        for (int i = 1; i <= 11; i++) begin
            cyc(k);
            if (i == 2)  chk({nm, "_busy_e1"}, busy, 1'b0);
            if (i == 3)  chk({nm, "_busy_e2"}, busy, 1'b1);
            if (i == 10) chk({nm, "_lvl_e9"}, key_level, ~k);
            if (i == 10) chk({nm, "_busy_e9"}, busy, 1'b1);
            if (i == 11) chk({nm, "_lvl_e10"}, key_level, k);
            if (i == 11) chk({nm, "_busy_e10"}, busy, 1'b0);
        end
    endtask

    initial begin
        seg_t tbl[$];
        bit   saw_busy;
        int   pulses;
        int   exp_pulses;

        tbl.push_back('{1'b0, 11, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  5, 1'b0, 1'b1});
        tbl.push_back('{1'b0,  3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 11, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  8, 1'b1, 1'b1});
        tbl.push_back('{1'b1,  2, 1'b1, 1'b1});
        tbl.push_back('{1'b1,  2, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  9, 1'b1, 1'b1});
        tbl.push_back('{1'b1,  1, 1'b1, 1'b1});
        tbl.push_back('{1'b1,  1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 12, 1'b1, 1'b0});

        rst_n  = 1'b0;
        key_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_level", key_level, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_long_press", long_press, 1'b0);
        rst_n = 1'b1;
        accept_11(1'b0, "post_reset");

        key_in = 1'b1;
        rst_pulse();
        foreach (tbl[s]) begin
            for (int i = 0; i < tbl[s].n; i++) cyc(tbl[s].k);
            chk($sformatf("table%0d_level", s), key_level, tbl[s].exp_lvl);
            chk($sformatf("table%0d_busy", s), busy, tbl[s].exp_busy);
        end

        accept_11(1'b0, "clean_press");
        accept_11(1'b1, "clean_release");

        saw_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            if (busy) saw_busy = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1);
            if (busy) saw_busy = 1'b1;
            chk("short_bounce_level", key_level, 1'b1);
        end
        chk("short_bounce_busy_seen", saw_busy, 1'b1);
        chk("short_bounce_busy_end", busy, 1'b0);

        for (int i = 0; i < 5; i++) cyc(1'b0);
        cyc(1'b1);
        for (int i = 1; i <= 11; i++) begin
            cyc(1'b0);
            if (i <= 10) chk("restart_not_early", key_level, 1'b1);
            if (i == 11) chk("restart_level_e10", key_level, 1'b0);
        end

        accept_11(1'b1, "release");
        for (int i = 1; i <= 4; i++) cyc(1'b0);
        chk("midfilter_busy", busy, 1'b1);
        rst_pulse();
        accept_11(1'b0, "after_midreset");

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        exp_pulses = 1;
`else
        exp_pulses = 0;
`endif
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0);
            if (long_press) pulses++;
            if (i == 15) chk("long_e15", long_press, 1'b0);
            if (i == 16) chk("long_e16", long_press, exp_pulses == 1);
            if (i == 17) chk("long_e17", long_press, 1'b0);
        end
        chk("long_single_pulse", 1'(pulses == exp_pulses), 1'b1);

        accept_11(1'b1, "long_release");
        accept_11(1'b0, "short_hold_press");
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0);
            if (long_press) pulses++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            if (long_press) pulses++;
        end
        chk("short_hold_no_pulse", 1'(pulses == 0), 1'b1);
        chk("short_hold_released", key_level, 1'b1);

        for (int s = 0; s < 250; s++) begin
            int   n;
            logic k;
            if ($urandom_range(0, 39) == 0) rst_pulse();
            k = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 30)) : int'($urandom_range(1, 11));
            for (int i = 0; i < n; i++) cyc(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
